// File: rtl/mult_pkg.sv
// Shared constants and types for the 16x9 sequential shift-add multiplier datapath.
package mult_pkg;

    localparam int MX_W  = 16;
    localparam int MY_W  = 9;
    localparam int ACC_W = MX_W + MY_W;
    localparam int CNT_W = $clog2(MY_W + 1);

    // Bits needed to count 0..max_count inclusive (at least one bit).
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

    typedef struct packed {
        logic load_mx;
        logic load_my;
        logic shift_my;
        logic clr_acc;
        logic load_acc;
        logic shift_in;
    } dp_ctrl_t;

endpackage

// File: rtl/shift_counter.sv
// Multiplier bit counter: clear on load, increment on shift, saturating at MY_W.
module shift_counter #(
    parameter int MY_W = mult_pkg::MY_W,
    parameter int CW   = mult_pkg::cnt_width(MY_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last_bit,
    output logic          done
);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (inc && (count_reg != CW'(MY_W))) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count    = count_reg;
    assign last_bit = (count_reg == CW'(MY_W - 1));
    assign done     = (count_reg == CW'(MY_W));

endmodule

// File: rtl/shift_add_datapath.sv
// Shift-add multiplier datapath: Mx, My/low-product shift register and carry-extended accumulator.
// Optional protocol checker enabled by defining DP_PROTOCOL_CHECK_EN (adds the proto_err port).
module shift_add_datapath #(
    parameter int MX_W = mult_pkg::MX_W,
    parameter int MY_W = mult_pkg::MY_W
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [MX_W-1:0]      Mx_in,
    input  logic [MY_W-1:0]      My_in,
    input  logic                 load_Mx,
    input  logic                 load_My,
    input  logic                 shift_My,
    input  logic                 clr_Acc,
    input  logic                 load_Acc,
    input  logic                 shift_in,
    output logic                 My_lsb,
    output logic                 last_bit,
    output logic [MX_W+MY_W-1:0] product,
    output logic                 product_valid
`ifdef DP_PROTOCOL_CHECK_EN
    ,
    output logic                 proto_err
`endif
);

    import mult_pkg::dp_ctrl_t;

    localparam int ACC_W = MX_W + MY_W;
    localparam int CW    = mult_pkg::cnt_width(MY_W);

    dp_ctrl_t        ctrl;
    logic [MX_W-1:0] mx_reg;
    logic [MX_W:0]   acc_reg;
    logic [MX_W:0]   acc_next;
    logic [MY_W-1:0] my_reg;
    logic [MY_W-1:0] my_next;
    logic            valid_reg;
    logic            valid_next;
    logic [CW-1:0]   count;
    logic            count_last;
    logic            count_done;
    logic            shift_ok;
    logic            serial_bit;

    assign ctrl = '{load_mx:  load_Mx,
                    load_my:  load_My,
                    shift_my: shift_My,
                    clr_acc:  clr_Acc,
                    load_acc: load_Acc,
                    shift_in: shift_in};

    // A shift is accepted only if no load overrides it and the product is not already complete.
    assign shift_ok = ctrl.shift_my && !ctrl.load_my && !count_done;

    // The bit leaving Acc enters My only when Acc really shifts this cycle.
    assign serial_bit = ctrl.shift_in && !ctrl.clr_acc && !ctrl.load_acc && acc_reg[0];

    shift_counter #(
        .MY_W (MY_W),
        .CW   (CW)
    ) u_shift_counter (
        .clk      (CLK),
        .rst      (RESET),
        .clear    (ctrl.load_my),
        .inc      (shift_ok),
        .count    (count),
        .last_bit (count_last),
        .done     (count_done)
    );

    always_comb begin
        acc_next = acc_reg;
        if (ctrl.clr_acc) begin
            acc_next = '0;
        end else if (ctrl.load_acc) begin
            acc_next = acc_reg + (my_reg[0] ? {1'b0, mx_reg} : '0);
        end else if (ctrl.shift_in) begin
            acc_next = {1'b0, acc_reg[MX_W:1]};
        end
    end

    always_comb begin
        my_next = my_reg;
        if (ctrl.load_my) begin
            my_next = My_in;
        end else if (shift_ok) begin
            my_next = {serial_bit, my_reg[MY_W-1:1]};
        end
    end

    always_comb begin
        valid_next = valid_reg;
        if (ctrl.load_my || ctrl.clr_acc) begin
            valid_next = 1'b0;
        end else if (shift_ok && count_last) begin
            valid_next = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mx_reg    <= '0;
            acc_reg   <= '0;
            my_reg    <= '0;
            valid_reg <= 1'b0;
        end else begin
            if (ctrl.load_mx) begin
                mx_reg <= Mx_in;
            end
            acc_reg   <= acc_next;
            my_reg    <= my_next;
            valid_reg <= valid_next;
        end
    end

`ifdef DP_PROTOCOL_CHECK_EN
    logic proto_err_reg;
    logic proto_viol;

    assign proto_viol = (ctrl.clr_acc && ctrl.load_acc)
                     || (ctrl.load_my && ctrl.shift_my)
                     || (ctrl.shift_my && count_done)
                     || (ctrl.shift_my && !ctrl.shift_in);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            proto_err_reg <= 1'b0;
        end else if (proto_viol) begin
            proto_err_reg <= 1'b1;
        end
    end

    assign proto_err = proto_err_reg;
`endif

    assign My_lsb        = my_reg[0];
    assign last_bit      = count_last;
    assign product       = {acc_reg[MX_W-1:0], my_reg};
    assign product_valid = valid_reg;

    // count is only consumed through its decodes; keep it visible for debug.
    logic unused_count;
    assign unused_count = ^count;

endmodule

// File: tb/tb_shift_add_datapath.sv
// Self-checking bench for shift_add_datapath: directed cases plus random operands vs. an arithmetic model.
// Define DP_PROTOCOL_CHECK_EN to also check the proto_err port.
module tb_shift_add_datapath;

    localparam int MX_W  = 16;
    localparam int MY_W  = 9;
    localparam int ACC_W = MX_W + MY_W;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [MX_W-1:0]  Mx_in;
    logic [MY_W-1:0]  My_in;
    logic             load_Mx, load_My, shift_My, clr_Acc, load_Acc, shift_in;
    logic             My_lsb;
    logic             last_bit;
    logic [ACC_W-1:0] product;
    logic             product_valid;
`ifdef DP_PROTOCOL_CHECK_EN
    logic             proto_err;
`endif

    int checks = 0;
    int errors = 0;

    shift_add_datapath dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .Mx_in         (Mx_in),
        .My_in         (My_in),
        .load_Mx       (load_Mx),
        .load_My       (load_My),
        .shift_My      (shift_My),
        .clr_Acc       (clr_Acc),
        .load_Acc      (load_Acc),
        .shift_in      (shift_in),
        .My_lsb        (My_lsb),
        .last_bit      (last_bit),
        .product       (product),
        .product_valid (product_valid)
`ifdef DP_PROTOCOL_CHECK_EN
        ,
        .proto_err     (proto_err)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock with the given strobes held; outputs are sampled 1 time unit after the edge.
    task automatic cycle(input bit lmx, input bit lmy, input bit smy, input bit clr, input bit lacc, input bit sin);
        load_Mx  = lmx;
        load_My  = lmy;
        shift_My = smy;
        clr_Acc  = clr;
        load_Acc = lacc;
        shift_in = sin;
        @(posedge CLK);
        #1;
        load_Mx  = 1'b0;
        load_My  = 1'b0;
        shift_My = 1'b0;
        clr_Acc  = 1'b0;
        load_Acc = 1'b0;
        shift_in = 1'b0;
    endtask

    // After k add/shift pairs the concatenation {Acc,My} holds the partial product of the k low
    // multiplier bits aligned to the top, above the multiplier bits not yet consumed.
    function automatic logic [63:0] model_product(input longint mx, input longint my, input int k);
        longint low_bits;
        low_bits = my & ((64'sd1 <<< k) - 1);
        return 64'((((mx * low_bits) <<< (MY_W - k)) | (my >>> k)) & ((64'sd1 <<< ACC_W) - 1));
    endfunction

    // Load operands and run `pairs` add/shift pairs, checking every intermediate state.
    task automatic run_op(input string name, input logic [MX_W-1:0] mx, input logic [MY_W-1:0] my,
                          input int pairs);
        Mx_in = mx;
        My_in = my;
        cycle(1, 1, 0, 1, 0, 0);
        check({name, " load valid"}, 64'(product_valid), 64'd0);
        check({name, " load product"}, 64'(product), model_product(mx, my, 0));
        for (int i = 0; i < pairs; i++) begin
            check($sformatf("%s lsb%0d", name, i), 64'(My_lsb), 64'(my[i]));
            check($sformatf("%s last%0d", name, i), 64'(last_bit), 64'(i == MY_W - 1));
            cycle(0, 0, 0, 0, 1, 0);
            cycle(0, 0, 1, 0, 0, 1);
            check($sformatf("%s prod%0d", name, i + 1), 64'(product), model_product(mx, my, i + 1));
            check($sformatf("%s valid%0d", name, i + 1), 64'(product_valid), 64'(i + 1 == MY_W));
        end
`ifdef DP_PROTOCOL_CHECK_EN
        check({name, " proto_err clean"}, 64'(proto_err), 64'd0);
`endif
        $display("op %-8s mx=0x%04h my=0x%03h pairs=%0d product=0x%07h valid=%0b",
                 name, mx, my, pairs, product, product_valid);
    endtask

    initial begin
        logic [MX_W-1:0] rmx;
        logic [MY_W-1:0] rmy;
        logic [63:0]     full;

        RESET = 1'b1;
        Mx_in = '0;
        My_in = '0;
        load_Mx = 0; load_My = 0; shift_My = 0; clr_Acc = 0; load_Acc = 0; shift_in = 0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset product", 64'(product), 64'd0);
        check("reset valid", 64'(product_valid), 64'd0);
        check("reset lsb", 64'(My_lsb), 64'd0);
        check("reset last", 64'(last_bit), 64'd0);
`ifdef DP_PROTOCOL_CHECK_EN
        check("reset proto_err", 64'(proto_err), 64'd0);
`endif
        RESET = 1'b0;

        // Directed operands, including the all-ones carry case and a zero multiplier.
        run_op("t1", 16'h1234, 9'h005, MY_W);
        check("t1 final", 64'(product), 64'h0005B04);
        run_op("t2", 16'hFFFF, 9'h1FF, MY_W);
        check("t2 final", 64'(product), 64'h1FEFE01);
        run_op("t3", 16'hABCD, 9'h000, MY_W);
        check("t3 final", 64'(product), 64'd0);

        // Asynchronous reset partway through an operation.
        run_op("t4a", 16'h8001, 9'h1A5, 4);
        #2 RESET = 1'b1;
        #1;
        check("t4 async product", 64'(product), 64'd0);
        check("t4 async valid", 64'(product_valid), 64'd0);
        check("t4 async lsb", 64'(My_lsb), 64'd0);
        check("t4 async last", 64'(last_bit), 64'd0);
        #2 RESET = 1'b0;
        run_op("t4b", 16'h00FF, 9'h101, MY_W);
        check("t4b final", 64'(product), 64'(32'h00FF * 32'h101));

        // Random operands against plain multiplication.
        for (int n = 0; n < 20; n++) begin
            rmx = MX_W'($urandom);
            rmy = MY_W'($urandom);
            run_op($sformatf("rnd%0d", n), rmx, rmy, MY_W);
            check($sformatf("rnd%0d mul", n), 64'(product), 64'(rmx) * 64'(rmy));
        end

        // Extra shift after completion and clr_Acc/load_Acc collision.
        run_op("t5", 16'hC3A5, 9'h0F3, MY_W);
        full = 64'(16'hC3A5) * 64'(9'h0F3);
        cycle(0, 0, 1, 0, 0, 0);
        check("t5 extra shift product", 64'(product), full);
        check("t5 extra shift valid", 64'(product_valid), 64'd1);
        check("t5 extra shift last", 64'(last_bit), 64'd0);
`ifdef DP_PROTOCOL_CHECK_EN
        check("t5 proto_err set", 64'(proto_err), 64'd1);
`endif
        cycle(0, 0, 0, 1, 1, 0);
        check("t5 clr product", 64'(product), full & 64'h1FF);
        check("t5 clr valid", 64'(product_valid), 64'd0);
        repeat (3) cycle(0, 0, 0, 0, 0, 0);
        check("t5 idle product", 64'(product), full & 64'h1FF);
`ifdef DP_PROTOCOL_CHECK_EN
        check("t5 proto_err sticky", 64'(proto_err), 64'd1);
`endif
        $display("op t5       extra shift + clr/load collision product=0x%07h", product);
        #2 RESET = 1'b1;
        #1;
        check("t5 reset product", 64'(product), 64'd0);
`ifdef DP_PROTOCOL_CHECK_EN
        check("t5 proto_err cleared", 64'(proto_err), 64'd0);
`endif
        #2 RESET = 1'b0;
        run_op("t6", 16'h0001, 9'h1FF, MY_W);
        check("t6 final", 64'(product), 64'h1FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
